// File: rtl/debug_controller.sv
// debug_controller: run-control and data-memory access controller for the
// 4-bit micro core. Gates core execution through cpu_en (halt, run, step,
// run-N, one program-address breakpoint) and, while the core is halted,
// lets the host read or write the 16x4 data memory through a command port.
module debug_controller #(
  parameter bit RESET_RUN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       cmd_err,
  input  logic [7:0] pm_address,
  input  logic [3:0] cpu_dm_addr,
  input  logic [3:0] cpu_dm_data,
  input  logic       cpu_wren,
  input  logic [3:0] dm_q,
  output logic [3:0] dm_addr,
  output logic [3:0] dm_data,
  output logic       dm_wren,
  output logic       cpu_en,
  output logic       halted,
  output logic       bp_hit,
  output logic       rsp_valid,
  output logic [3:0] rsp_data
);

  localparam logic [2:0] S_HALTED   = 3'd0;
  localparam logic [2:0] S_RUNNING  = 3'd1;
  localparam logic [2:0] S_STEPPING = 3'd2;
  localparam logic [2:0] S_DM_RD    = 3'd3;
  localparam logic [2:0] S_DM_WR    = 3'd4;

  localparam logic [2:0] CMD_CLR_BP   = 3'd0;
  localparam logic [2:0] CMD_HALT     = 3'd1;
  localparam logic [2:0] CMD_RUN      = 3'd2;
  localparam logic [2:0] CMD_STEP     = 3'd3;
  localparam logic [2:0] CMD_RUN_N    = 3'd4;
  localparam logic [2:0] CMD_DM_READ  = 3'd5;
  localparam logic [2:0] CMD_DM_WRITE = 3'd6;
  localparam logic [2:0] CMD_SET_BP   = 3'd7;

  logic [2:0] state, state_n;
  logic [7:0] bp_addr, bp_addr_n;
  logic       bp_valid, bp_valid_n;
  logic [7:0] count, count_n;
  logic       skip, skip_n;
  logic [3:0] lat_addr, lat_addr_n;
  logic [3:0] lat_data, lat_data_n;
  logic       err_n, hit_n;

  logic active;
  logic bphit;
  logic accept;

  // Core may advance only while running/stepping and not parked on a breakpoint.
  // The skip flag masks the breakpoint for the first cycle after resuming, so
  // the instruction sitting at the breakpoint address executes on resume.
  assign active    = (state == S_RUNNING) || (state == S_STEPPING);
  assign bphit     = active & bp_valid & (pm_address == bp_addr) & ~skip;
  assign cpu_en    = active & ~bphit;
  assign halted    = ~active;
  assign cmd_ready = (state == S_HALTED) || active;
  assign accept    = cmd_valid & cmd_ready;

  // Data-memory port: the core owns it while enabled; otherwise the latched
  // host address/data drive it and only a host write may assert the enable.
  assign dm_addr = cpu_en ? cpu_dm_addr : lat_addr;
  assign dm_data = cpu_en ? cpu_dm_data : lat_data;
  assign dm_wren = cpu_en ? cpu_wren : (state == S_DM_WR);

  // Next-state and register-update decisions for one clock edge.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would make synthesis infer a latch to hold it.
    state_n    = state;
    bp_addr_n  = bp_addr;
    bp_valid_n = bp_valid;
    count_n    = count;
    skip_n     = skip;
    lat_addr_n = lat_addr;
    lat_data_n = lat_data;
    err_n      = 1'b0;
    hit_n      = 1'b0;

    unique case (state)
      S_HALTED: begin
        if (accept) begin
          unique case (cmd)
            CMD_RUN: begin
              state_n = S_RUNNING;
              skip_n  = 1'b1;
            end
            CMD_STEP: begin
              state_n = S_STEPPING;
              count_n = 8'd1;
              skip_n  = 1'b1;
            end
            CMD_RUN_N: begin
              // A zero count is accepted silently and leaves the core halted.
              if (cmd_arg != 8'd0) begin
                state_n = S_STEPPING;
                count_n = cmd_arg;
                skip_n  = 1'b1;
              end
            end
            CMD_DM_READ: begin
              state_n    = S_DM_RD;
              lat_addr_n = cmd_arg[7:4];
            end
            CMD_DM_WRITE: begin
              state_n    = S_DM_WR;
              lat_addr_n = cmd_arg[7:4];
              lat_data_n = cmd_arg[3:0];
            end
            CMD_SET_BP: begin
              bp_addr_n  = cmd_arg;
              bp_valid_n = 1'b1;
            end
            CMD_CLR_BP: bp_valid_n = 1'b0;
            default: ;  // HALT while halted does nothing
          endcase
        end
      end

      S_RUNNING, S_STEPPING: begin
        skip_n = 1'b0;
        // The step count never wraps: the edge that consumes the last step halts.
        if ((state == S_STEPPING) && cpu_en) begin
          count_n = count - 8'd1;
          if (count == 8'd1) state_n = S_HALTED;
        end
        if (bphit) begin
          state_n = S_HALTED;
          hit_n   = 1'b1;
        end
        if (accept) begin
          unique case (cmd)
            CMD_HALT:   state_n = S_HALTED;
            CMD_SET_BP: begin
              bp_addr_n  = cmd_arg;
              bp_valid_n = 1'b1;
            end
            CMD_CLR_BP: bp_valid_n = 1'b0;
            default:    err_n = 1'b1;  // run/step/memory commands need a halted core
          endcase
        end
      end

      S_DM_RD, S_DM_WR: state_n = S_HALTED;

      default: state_n = S_HALTED;
    endcase
  end

  // Control registers; reset forces the configured run state immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state    <= RESET_RUN ? S_RUNNING : S_HALTED;
      bp_addr  <= 8'd0;
      bp_valid <= 1'b0;
      count    <= 8'd0;
      skip     <= 1'b1;
      lat_addr <= 4'd0;
      lat_data <= 4'd0;
      cmd_err  <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      state    <= state_n;
      bp_addr  <= bp_addr_n;
      bp_valid <= bp_valid_n;
      count    <= count_n;
      skip     <= skip_n;
      lat_addr <= lat_addr_n;
      lat_data <= lat_data_n;
      cmd_err  <= err_n;
      bp_hit   <= hit_n;
    end
  end

  // Host read response: capture memory data at the edge closing the read cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 4'd0;
    end else begin
      rsp_valid <= (state == S_DM_RD);
      if (state == S_DM_RD) rsp_data <= dm_q;
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: directed and randomized bench for debug_controller.
// A simple core (program counter that advances on cpu_en) and a 16x4 data
// memory surround the DUT; a transaction-level reference model predicts
// every output each cycle.
module tb_debug_controller;

  localparam logic [2:0] C_CLR   = 3'd0;
  localparam logic [2:0] C_HALT  = 3'd1;
  localparam logic [2:0] C_RUN   = 3'd2;
  localparam logic [2:0] C_STEP  = 3'd3;
  localparam logic [2:0] C_RUN_N = 3'd4;
  localparam logic [2:0] C_READ  = 3'd5;
  localparam logic [2:0] C_WRITE = 3'd6;
  localparam logic [2:0] C_SET   = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       cmd_err;
  logic [7:0] pm_address;
  logic [3:0] cpu_dm_addr;
  logic [3:0] cpu_dm_data;
  logic       cpu_wren;
  logic [3:0] dm_q;
  logic [3:0] dm_addr;
  logic [3:0] dm_data;
  logic       dm_wren;
  logic       cpu_en;
  logic       halted;
  logic       bp_hit;
  logic       rsp_valid;
  logic [3:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_en  = 0;
  int n_hit = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debug_controller #(.RESET_RUN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .cmd_err    (cmd_err),
    .pm_address (pm_address),
    .cpu_dm_addr(cpu_dm_addr),
    .cpu_dm_data(cpu_dm_data),
    .cpu_wren   (cpu_wren),
    .dm_q       (dm_q),
    .dm_addr    (dm_addr),
    .dm_data    (dm_data),
    .dm_wren    (dm_wren),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  // Data memory: asynchronous read, write at the negedge of the cycle.
  logic [3:0] mem [16] = '{default: 4'h0};
  always @(negedge clk) if (dm_wren) mem[dm_addr] <= dm_data;
  assign dm_q = mem[dm_addr];

  // Reference model, kept as "is the core allowed to run", "steps left"
  // (-1 = unlimited) and "pending host memory operation".
  bit         m_exec;
  int         m_left;
  bit         m_fresh;
  bit         m_bpv;
  logic [7:0] m_bp;
  int         m_op;      // 0 none, 1 read, 2 write
  logic [3:0] m_a, m_d;
  logic [3:0] ref_mem [16] = '{default: 4'h0};
  bit         e_err, e_hit, e_rv;
  logic [3:0] e_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exec = 1'b1; m_left = -1; m_fresh = 1'b1;
    m_bpv = 1'b0; m_bp = 8'd0; m_op = 0; m_a = 4'd0; m_d = 4'd0;
    e_err = 1'b0; e_hit = 1'b0; e_rv = 1'b0; e_rd = 4'd0;
  endtask

  task automatic model_edge(input bit en, input bit hit);
    bit acc;
    bit stop;
    acc  = cmd_valid && (m_op == 0);
    stop = 1'b0;
    e_err = 1'b0; e_hit = 1'b0; e_rv = 1'b0;
    if (m_op == 1) begin
      e_rv = 1'b1; e_rd = ref_mem[m_a]; m_op = 0;
    end else if (m_op == 2) begin
      m_op = 0;
    end else if (m_exec) begin
      m_fresh = 1'b0;
      if (en && m_left > 0) begin
        m_left--;
        if (m_left == 0) stop = 1'b1;
      end
      if (hit) begin stop = 1'b1; e_hit = 1'b1; end
      if (acc) begin
        case (cmd)
          C_HALT: stop = 1'b1;
          C_SET:  begin m_bp = cmd_arg; m_bpv = 1'b1; end
          C_CLR:  m_bpv = 1'b0;
          default: e_err = 1'b1;
        endcase
      end
      if (stop) m_exec = 1'b0;
    end else if (acc) begin
      case (cmd)
        C_RUN:   begin m_exec = 1'b1; m_left = -1; m_fresh = 1'b1; end
        C_STEP:  begin m_exec = 1'b1; m_left = 1;  m_fresh = 1'b1; end
        C_RUN_N: if (cmd_arg != 8'd0) begin m_exec = 1'b1; m_left = int'(cmd_arg); m_fresh = 1'b1; end
        C_READ:  begin m_op = 1; m_a = cmd_arg[7:4]; end
        C_WRITE: begin m_op = 2; m_a = cmd_arg[7:4]; m_d = cmd_arg[3:0]; end
        C_SET:   begin m_bp = cmd_arg; m_bpv = 1'b1; end
        C_CLR:   m_bpv = 1'b0;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: entered at posedge+1 with inputs set; checks outputs,
  // advances the model, then returns at the next posedge+1.
  task automatic cyc();
    bit hit, en, ew, en_s;
    logic [3:0] ea, ed;
    #1;
    hit = m_exec && m_bpv && (pm_address == m_bp) && !m_fresh;
    en  = m_exec && !hit;
    ew  = en ? cpu_wren : (m_op == 2);
    ea  = en ? cpu_dm_addr : m_a;
    ed  = en ? cpu_dm_data : m_d;
    check("cpu_en", cpu_en, en);
    check("halted", halted, !m_exec);
    check("cmd_ready", cmd_ready, m_op == 0);
    check("dm_wren", dm_wren, ew);
    if (en || m_op != 0) check("dm_addr", dm_addr, ea);
    if (ew) check("dm_data", dm_data, ed);
    check("cmd_err", cmd_err, e_err);
    check("bp_hit", bp_hit, e_hit);
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_data", rsp_data, e_rd);
    n_en  += int'(cpu_en);
    n_hit += int'(bp_hit);
    n_err += int'(cmd_err);
    if (ew) ref_mem[ea] = ed;
    model_edge(en, hit);
    en_s = cpu_en;
    @(posedge clk);
    #1;
    if (en_s) pm_address = pm_address + 8'd1;
    cmd_valid = 1'b0;
    cpu_wren  = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] a);
    cmd_valid = 1'b1; cmd = c; cmd_arg = a;
    cyc();
  endtask

  // Asynchronous reset asserted mid-cycle; entered and left at posedge+1.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_cpu_en", cpu_en, 1);
    check("rst_halted", halted, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; pm_address = 8'd0; cmd_valid = 1'b0; cpu_wren = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; cmd_arg = 8'd0;
    pm_address = 8'd0; cpu_dm_addr = 4'd0; cpu_dm_data = 4'd0; cpu_wren = 1'b0;
    model_reset();
    #2;
    check("por_cpu_en", cpu_en, 1);
    check("por_halted", halted, 0);
    check("por_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) cyc();
    send(C_HALT, 8'd0);
    cyc();

    // Single step from 0x03, then run-N 5 and run-N 0.
    pm_address = 8'h03; n_en = 0;
    send(C_STEP, 8'd0);
    repeat (4) cyc();
    check("step_cycles", n_en, 1);
    check("step_pm", pm_address, 8'h04);
    n_en = 0;
    send(C_RUN_N, 8'd5);
    repeat (8) cyc();
    check("run5_cycles", n_en, 5);
    n_en = 0; n_err = 0;
    send(C_RUN_N, 8'd0);
    repeat (3) cyc();
    check("run0_cycles", n_en, 0);
    check("run0_err", n_err, 0);

    // Breakpoint at 0x07, resume past it, then clear it.
    send(C_SET, 8'h07);
    pm_address = 8'h00; n_en = 0; n_hit = 0;
    send(C_RUN, 8'd0);
    repeat (12) cyc();
    check("bp_hits", n_hit, 1);
    check("bp_pm", pm_address, 8'h07);
    check("bp_exec", n_en, 7);
    n_hit = 0;
    send(C_RUN, 8'd0);
    repeat (4) cyc();
    check("resume_pm", pm_address, 8'h0B);
    send(C_CLR, 8'd0);
    pm_address = 8'h05;
    repeat (5) cyc();
    check("clr_no_hit", n_hit, 0);
    check("clr_pm", pm_address, 8'h0A);
    send(C_HALT, 8'd0);

    // Host write then read back.
    send(C_WRITE, 8'hA5);
    cyc();
    check("wr_mem", mem[10], 4'h5);
    send(C_READ, 8'hA0);
    cyc();
    check("rd_valid", rsp_valid, 1);
    check("rd_data", rsp_data, 4'h5);
    cyc();

    // Memory access refused while running; core writes pass through.
    send(C_RUN, 8'd0);
    send(C_READ, 8'hA0);
    check("run_rd_err", cmd_err, 1);
    cpu_wren = 1'b1; cpu_dm_addr = 4'h3; cpu_dm_data = 4'h9;
    cyc();
    check("cpu_wr_mem", mem[3], 4'h9);
    send(C_HALT, 8'd0);
    send(C_READ, 8'hA0);
    cyc();
    check("halt_rd_valid", rsp_valid, 1);
    check("halt_rd_data", rsp_data, 4'h5);
    cpu_wren = 1'b1; cpu_dm_addr = 4'h4; cpu_dm_data = 4'hF;
    cyc();
    check("halt_cpu_wr_blocked", mem[4], 4'h0);

    // Reset during a host read aborts it.
    send(C_READ, 8'h30);
    check("pre_rst_halted", halted, 1);
    do_reset();
    repeat (3) cyc();

    // Longest step count.
    send(C_HALT, 8'd0);
    pm_address = 8'd0; n_en = 0;
    send(C_RUN_N, 8'd255);
    repeat (260) cyc();
    check("run255_cycles", n_en, 255);

    // Randomized command traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) pm_address = 8'($urandom_range(0, 15));
      cpu_wren    = 1'($urandom_range(0, 1));
      cpu_dm_addr = 4'($urandom);
      cpu_dm_data = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd = 3'($urandom);
        if (cmd == C_RUN_N) cmd_arg = 8'($urandom_range(0, 6));
        else if (cmd == C_SET) cmd_arg = 8'($urandom_range(0, 15));
        else cmd_arg = 8'($urandom);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
